// File: rtl/match_game_if.sv
// match_game_if: signal bundle between the game front end and match_game_core
//   front end -> core : start, pause, guess_valid, guess[DATA_W], target[DATA_W]
//   core -> front end : playing, game_over, correct, wrong, new_target,
//                       timer_bcd[4*TIMER_DIGITS], score_bcd/high_bcd[4*SCORE_DIGITS]
interface match_game_if #(
    parameter int DATA_W       = 4,
    parameter int TIMER_DIGITS = 2,
    parameter int SCORE_DIGITS = 2
);
    logic                      start;
    logic                      pause;
    logic                      guess_valid;
    logic [DATA_W-1:0]         guess;
    logic [DATA_W-1:0]         target;
    logic                      playing;
    logic                      game_over;
    logic                      correct;
    logic                      wrong;
    logic                      new_target;
    logic [4*TIMER_DIGITS-1:0] timer_bcd;
    logic [4*SCORE_DIGITS-1:0] score_bcd;
    logic [4*SCORE_DIGITS-1:0] high_bcd;

    modport master (
        output start, pause, guess_valid, guess, target,
        input  playing, game_over, correct, wrong, new_target, timer_bcd, score_bcd, high_bcd
    );
    modport slave (
        input  start, pause, guess_valid, guess, target,
        output playing, game_over, correct, wrong, new_target, timer_bcd, score_bcd, high_bcd
    );
endinterface

// File: rtl/match_game_core.sv
// match_game_core: round engine with BCD countdown, BCD score and persistent high score
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset (also clears the high score)
//   bus   : match_game_if.slave -- start/pause/guess_valid/guess/target in,
//           playing/game_over/correct/wrong/new_target pulses and BCD displays out
module match_game_core #(
    parameter int                DATA_W       = 4,
    parameter logic [DATA_W-1:0] MATCH_VALUE  = 4'hF,
    parameter int                TIMER_DIGITS = 2,
    parameter int                TIMER_START  = 99,
    parameter int                SCORE_DIGITS = 2,
    parameter int                TICK_DIV     = 50000000
) (
    input logic         clk,
    input logic         rst_n,
    match_game_if.slave bus
);
    localparam int TW = 4*TIMER_DIGITS;
    localparam int SW = 4*SCORE_DIGITS;
    localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [SW-1:0] ALL9 = {SCORE_DIGITS{4'h9}};

    function automatic logic [TW-1:0] to_bcd(input int v);
        logic [TW-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < TIMER_DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    localparam logic [TW-1:0] TIMER_LOAD = to_bcd(TIMER_START);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t            state, state_d;
    logic [DW-1:0]     div;
    logic [TW-1:0]     timer, timer_dec;
    logic [SW-1:0]     score, score_inc, score_d, high;
    logic [DATA_W-1:0] sum;
    logic              borrow, carry, run, tick, timeout, hit, match;
    logic              correct, wrong, new_target;

    always_comb begin
        borrow = 1'b1;
        timer_dec = timer;
        for (int i = 0; i < TIMER_DIGITS; i++) begin
            timer_dec[4*i +: 4] = borrow ? ((timer[4*i +: 4] == 4'd0) ? 4'd9 : timer[4*i +: 4] - 4'd1) : timer[4*i +: 4];
            borrow = borrow && (timer[4*i +: 4] == 4'd0);
        end
    end

    always_comb begin
        carry = 1'b1;
        score_inc = score;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            score_inc[4*i +: 4] = carry ? ((score[4*i +: 4] == 4'd9) ? 4'd0 : score[4*i +: 4] + 4'd1) : score[4*i +: 4];
            carry = carry && (score[4*i +: 4] == 4'd9);
        end
    end

    assign sum     = bus.guess + bus.target;
    assign match   = sum == MATCH_VALUE;
    // start takes priority over a guess in the same cycle
    assign hit     = bus.guess_valid && state == PLAY && !bus.start;
    assign run     = state == PLAY && !bus.pause;
    assign tick    = run && div == DW'(TICK_DIV-1);
    assign timeout = tick && timer == TW'(1);
    // saturate at all-9s; this is also the value the high score sees on timeout
    assign score_d = (hit && match && score != ALL9) ? score_inc : score;

    always_comb begin
        state_d = bus.start ? PLAY : (timeout ? OVER : state);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div        <= '0;
            timer      <= TIMER_LOAD;
            score      <= '0;
            high       <= '0;
            correct    <= 1'b0;
            wrong      <= 1'b0;
            new_target <= 1'b0;
        end else begin
            correct    <= hit && match;
            wrong      <= hit && !match;
            new_target <= bus.start || (hit && match);
            // packed BCD compares correctly as plain binary
            if (timeout && score_d > high) high <= score_d;
            if (bus.start) begin
                div   <= '0;
                timer <= TIMER_LOAD;
                score <= '0;
            end else begin
                score <= score_d;
                if (run) div <= tick ? '0 : div + 1'b1;
                if (tick && timer != '0) timer <= timer_dec;
            end
        end
    end

    assign bus.playing    = state == PLAY;
    assign bus.game_over  = state == OVER;
    assign bus.correct    = correct;
    assign bus.wrong      = wrong;
    assign bus.new_target = new_target;
    assign bus.timer_bcd  = timer;
    assign bus.score_bcd  = score;
    assign bus.high_bcd   = high;
endmodule

// File: tb/tb_match_game_core.sv
// tb_match_game_core: directed scenarios plus random stimulus checked against an integer game model
module tb_match_game_core;
    localparam logic [3:0] MATCH = 4'hF;
    localparam int TS   = 12;
    localparam int TICK = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    match_game_if #(.DATA_W(4), .TIMER_DIGITS(2), .SCORE_DIGITS(2)) bus();

    match_game_core #(
        .DATA_W(4), .MATCH_VALUE(4'hF), .TIMER_DIGITS(2), .TIMER_START(TS),
        .SCORE_DIGITS(2), .TICK_DIV(TICK)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // game model in plain integers: seconds left, points, best, cycles into the current second
    int m_timer, m_score, m_high, m_phase;
    bit m_play, m_over, m_cor, m_wrong, m_nt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_timer <= TS; m_score <= 0; m_high <= 0; m_phase <= 0;
            m_play <= 0; m_over <= 0; m_cor <= 0; m_wrong <= 0; m_nt <= 0;
        end else begin : upd
            bit hit, ok, tk;
            int ns;
            hit = m_play && bus.guess_valid && !bus.start;
            ok  = ((int'(bus.guess) + int'(bus.target)) % 16) == int'(MATCH);
            ns  = (hit && ok && m_score < 99) ? m_score + 1 : m_score;
            tk  = m_play && !bus.pause && m_phase == TICK - 1;
            m_cor   <= hit && ok;
            m_wrong <= hit && !ok;
            m_nt    <= bus.start || (hit && ok);
            if (tk && m_timer == 1 && ns > m_high) m_high <= ns;
            if (bus.start) begin
                m_play <= 1; m_over <= 0; m_timer <= TS; m_score <= 0; m_phase <= 0;
            end else begin
                m_score <= ns;
                if (m_play && !bus.pause) m_phase <= (m_phase + 1) % TICK;
                if (tk) begin
                    m_timer <= m_timer - 1;
                    if (m_timer == 1) begin m_play <= 0; m_over <= 1; end
                end
            end
        end
    end

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk($sformatf("cycle_t%0t", $time),
            {3'b0, bus.playing, bus.game_over, bus.correct, bus.wrong, bus.new_target,
             bus.timer_bcd, bus.score_bcd, bus.high_bcd},
            {3'b0, m_play, m_over, m_cor, m_wrong, m_nt, bcd(m_timer), bcd(m_score), bcd(m_high)});
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic guess_once(input logic [3:0] g, input logic [3:0] t);
        bus.guess = g;
        bus.target = t;
        bus.guess_valid = 1'b1;
        step();
        bus.guess_valid = 1'b0;
    endtask

    task automatic score_n(input int n);
        for (int i = 0; i < n; i++) begin
            logic [3:0] g;
            g = 4'($urandom);
            guess_once(g, MATCH - g);
        end
    endtask

    task automatic run_to_over();
        int n;
        n = 0;
        bus.pause = 1'b0;
        while (!bus.game_over && n < 200) begin
            step();
            n++;
        end
        chk("reach_over", 32'(bus.game_over), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int n;
        bus.start = 0; bus.pause = 0; bus.guess_valid = 0; bus.guess = 0; bus.target = 0;
        repeat (3) step();
        chk("rst_timer", bus.timer_bcd, 8'h12);
        chk("rst_score", bus.score_bcd, 8'h00);
        chk("rst_high", bus.high_bcd, 8'h00);
        chk("rst_playing", 32'(bus.playing), 0);
        rst_n = 1'b1;
        step();

        // full countdown
        pulse_start();
        chk("t1_playing", 32'(bus.playing), 1);
        chk("t1_timer", bus.timer_bcd, 8'h12);
        chk("t1_new_target", 32'(bus.new_target), 1);
        chk("t1_model_timer", bcd(m_timer), 8'h12);
        n = 0;
        while (!bus.game_over && n < 200) begin
            step();
            n++;
        end
        chk("t1_cycles", n, 48);
        chk("t1_timer_end", bus.timer_bcd, 8'h00);
        chk("t1_game_over", 32'(bus.game_over), 1);

        // correct/wrong guesses and BCD carry/borrow
        bus.pause = 1'b1;
        pulse_start();
        guess_once(4'h9, 4'h6);
        chk("t2_correct", 32'(bus.correct), 1);
        chk("t2_new_target", 32'(bus.new_target), 1);
        chk("t2_score", bus.score_bcd, 8'h01);
        guess_once(4'h3, 4'h6);
        chk("t2_wrong", 32'(bus.wrong), 1);
        chk("t2_no_correct", 32'(bus.correct), 0);
        chk("t2_score_held", bus.score_bcd, 8'h01);
        score_n(8);
        chk("t3_score9", bus.score_bcd, 8'h09);
        chk("t3_model_score9", bcd(m_score), 8'h09);
        score_n(1);
        chk("t3_score10", bus.score_bcd, 8'h10);
        bus.pause = 1'b0;
        n = 0;
        while (bus.timer_bcd != 8'h10 && n < 50) begin step(); n++; end
        chk("t3_timer10", bus.timer_bcd, 8'h10);
        n = 0;
        while (bus.timer_bcd == 8'h10 && n < 50) begin step(); n++; end
        chk("t3_timer09", bus.timer_bcd, 8'h09);
        run_to_over();
        chk("t3_high", bus.high_bcd, 8'h10);

        // reset mid-game
        bus.pause = 1'b1;
        pulse_start();
        score_n(2);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_high", bus.high_bcd, 8'h00);
        chk("rst_mid_timer", bus.timer_bcd, 8'h12);
        chk("rst_mid_score", bus.score_bcd, 8'h00);
        chk("rst_mid_playing", 32'(bus.playing), 0);
        step();
        rst_n = 1'b1;
        step();

        // high score tracking
        bus.pause = 1'b1; pulse_start(); score_n(3); run_to_over();
        chk("t5_high3", bus.high_bcd, 8'h03);
        bus.pause = 1'b1; pulse_start(); score_n(2); run_to_over();
        chk("t5_high_kept", bus.high_bcd, 8'h03);
        bus.pause = 1'b1; pulse_start(); score_n(5); run_to_over();
        chk("t5_high5", bus.high_bcd, 8'h05);

        // guess on the final tick
        do_reset();
        bus.pause = 1'b0;
        pulse_start();
        repeat (47) step();
        guess_once(4'h7, 4'h8);
        chk("t6_over", 32'(bus.game_over), 1);
        chk("t6_correct", 32'(bus.correct), 1);
        chk("t6_score", bus.score_bcd, 8'h01);
        chk("t6_high", bus.high_bcd, 8'h01);

        // start + guess in the same cycle
        bus.pause = 1'b1;
        pulse_start();
        score_n(2);
        chk("t6_score2", bus.score_bcd, 8'h02);
        bus.start = 1'b1;
        guess_once(4'h1, 4'hE);
        bus.start = 1'b0;
        chk("t6_sg_score", bus.score_bcd, 8'h00);
        chk("t6_sg_correct", 32'(bus.correct), 0);
        chk("t6_sg_wrong", 32'(bus.wrong), 0);
        chk("t6_sg_new_target", 32'(bus.new_target), 1);

        // pause freezes the countdown
        bus.pause = 1'b0;
        repeat (6) step();
        chk("t6_timer11", bus.timer_bcd, 8'h11);
        bus.pause = 1'b1;
        repeat (10) step();
        chk("t6_pause", bus.timer_bcd, 8'h11);
        bus.pause = 1'b0;
        repeat (2) step();
        chk("t6_resume", bus.timer_bcd, 8'h10);

        // start + timeout in the same cycle
        bus.pause = 1'b1;
        pulse_start();
        score_n(4);
        bus.pause = 1'b0;
        repeat (47) step();
        pulse_start();
        chk("st_playing", 32'(bus.playing), 1);
        chk("st_timer", bus.timer_bcd, 8'h12);
        chk("st_score", bus.score_bcd, 8'h00);
        chk("st_high", bus.high_bcd, 8'h04);

        // score saturation
        bus.pause = 1'b1;
        pulse_start();
        score_n(99);
        chk("t4_score99", bus.score_bcd, 8'h99);
        guess_once(4'h5, 4'hA);
        chk("t4_correct", 32'(bus.correct), 1);
        chk("t4_sat", bus.score_bcd, 8'h99);
        run_to_over();
        chk("t4_high", bus.high_bcd, 8'h99);

        // random play
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] g;
            g = 4'($urandom);
            bus.start = $urandom_range(0, 119) == 0;
            bus.pause = $urandom_range(0, 7) == 0;
            bus.guess_valid = $urandom_range(0, 2) == 0;
            bus.guess = g;
            bus.target = $urandom_range(0, 1) ? MATCH - g : 4'($urandom);
            rst_n = $urandom_range(0, 599) != 0;
            step();
        end
        rst_n = 1'b1;
        bus.start = 0;
        bus.guess_valid = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
